// File: rtl/pixel_fetch_if.sv
// SRAM read port between pixel_fetch (master) and the external asynchronous SRAM (slave).
interface pixel_fetch_if;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic [15:0] sram_rdata;

    modport master (
        output SRAM_ADDR,
        output SRAM_CE_N,
        output SRAM_OE_N,
        input  sram_rdata
    );

    modport slave (
        input  SRAM_ADDR,
        input  SRAM_CE_N,
        input  SRAM_OE_N,
        output sram_rdata
    );
endinterface

// File: rtl/pixel_fetch.sv
// Double-buffered line fetcher: copies one framebuffer row from SRAM into a line bank while
// the other bank feeds pix_out. Define PIXEL_FETCH_LINE_DOUBLE_EN to map two display lines per row.
module pixel_fetch #(
    parameter logic [19:0] FB_BASE  = 20'h00000,
    parameter int          H_PIXELS = 640
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                line_start,
    input  logic [9:0]          line_y,
    input  logic [9:0]          rd_x,
    output logic [3:0]          pix_out,
    output logic                busy,
    output logic                underrun,
    pixel_fetch_if.master       sram
);

    localparam int WORDS = H_PIXELS / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_W = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [9:0]         row_sel;
    logic [9:0]         row;
    logic [IDX_W-1:0]   w;
    logic [IDX_W-1:0]   w_inc;
    logic [19:0]        addr;
    logic               disp_bank;
    logic               underrun_q;
    logic               vld_p1;
    logic [IDX_W-1:0]   wr_idx_p1;
    logic [15:0]        bank [2][WORDS];
    logic               rd_ok;
    logic [IDX_W-1:0]   rd_idx;
    logic [15:0]        rd_word;
    logic [3:0]         pix_p1;
    logic               active;

`ifdef PIXEL_FETCH_LINE_DOUBLE_EN
    assign row_sel = {1'b0, line_y[9:1]};
`else
    assign row_sel = line_y;
`endif

    function automatic logic [19:0] calc_addr(input logic [9:0] r, input logic [IDX_W-1:0] idx);
        return FB_BASE + 20'(r) * 20'(WORDS) + 20'(idx);
    endfunction

    assign w_inc = w + IDX_W'(1);

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A start seen in DRAIN behaves like one seen in IDLE; only FETCH treats it as an overrun restart.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (line_start) state_nxt = FETCH;
            FETCH:   if (line_start) state_nxt = FETCH;
                     else if (w == LAST_W) state_nxt = DRAIN;
            DRAIN:   state_nxt = line_start ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        active = (state == FETCH) || (state == DRAIN);
        busy   = active;
        sram.SRAM_CE_N = !active;
        sram.SRAM_OE_N = !active;
    end

    assign sram.SRAM_ADDR = addr;
    assign underrun       = underrun_q;

    // Stage p0: address issue; stage p1: write of the word returned for that address.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            disp_bank  <= 1'b0;
            underrun_q <= 1'b0;
            w          <= '0;
            row        <= '0;
            addr       <= '0;
            vld_p1     <= 1'b0;
        end else if (line_start) begin
            row    <= row_sel;
            w      <= '0;
            addr   <= calc_addr(row_sel, '0);
            vld_p1 <= 1'b0;
            if (state == FETCH) underrun_q <= 1'b1;
            else                disp_bank  <= ~disp_bank;
        end else if (state == FETCH) begin
            vld_p1 <= 1'b1;
            if (w != LAST_W) begin
                w    <= w_inc;
                addr <= calc_addr(row, w_inc);
            end
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (state == FETCH) wr_idx_p1 <= w;
        if (Reset_n && vld_p1) bank[~disp_bank][wr_idx_p1] <= sram.sram_rdata;
    end

    // Read side: the fill bank is always the other bank, so writes never disturb displayed data.
    assign rd_ok   = int'(rd_x) < H_PIXELS;
    assign rd_idx  = rd_ok ? rd_x[IDX_W+1:2] : '0;
    assign rd_word = bank[disp_bank][rd_idx];

    always_ff @(posedge Clk) begin
        if (!Reset_n)   pix_p1 <= 4'h0;
        else if (rd_ok) pix_p1 <= rd_word[{rd_x[1:0], 2'b00} +: 4];
        else            pix_p1 <= 4'h0;
    end

    assign pix_out = pix_p1;

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch: fetch timing, bank swap, underrun restart, coincident start, reset abort.
module tb_pixel_fetch;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       line_start;
    logic [9:0] line_y;
    logic [9:0] rd_x;
    logic [3:0] pix_out;
    logic       busy;
    logic       underrun;
    logic       use_model;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;

    pixel_fetch_if sram_bus();

    pixel_fetch dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .line_start (line_start),
        .line_y     (line_y),
        .rd_x       (rd_x),
        .pix_out    (pix_out),
        .busy       (busy),
        .underrun   (underrun),
        .sram       (sram_bus)
    );

    always #10 Clk = ~Clk;

    function automatic logic [15:0] mem_fn(input logic [19:0] a);
        return {a[3:0], ~a[3:0], a[7:4] ^ 4'h6, a[3:0] ^ 4'h9};
    endfunction

    function automatic logic [3:0] exp_pix(input int x);
        logic [15:0] wd;
        if (x >= 640) return 4'h0;
        wd = mem_fn(20'(x / 4));
        return wd[(x % 4) * 4 +: 4];
    endfunction

    // SRAM model: data for the address seen at an edge is presented during the following cycle.
    always @(posedge Clk)
        sram_bus.sram_rdata <= use_model ? mem_fn(sram_bus.SRAM_ADDR) : 16'h3210;

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [19:0] base_c;
    logic [19:0] base_d;
    int          xs [4] = '{0, 5, 318, 639};
    int          x;

    initial begin
`ifdef PIXEL_FETCH_LINE_DOUBLE_EN
        base_c = 20'd320;
        base_d = 20'd160;
`else
        base_c = 20'd800;
        base_d = 20'd480;
`endif
        Reset_n = 1'b0; line_start = 1'b0; line_y = '0; rd_x = '0; use_model = 1'b0;
        tick(); tick();
        check("rst_addr", 32'(sram_bus.SRAM_ADDR), 0);
        check("rst_ce", 32'(sram_bus.SRAM_CE_N), 1);
        check("rst_oe", 32'(sram_bus.SRAM_OE_N), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_pix", 32'(pix_out), 0);
        Reset_n = 1'b1;
        tick();

        // Fetch A: row 2, constant data 16'h3210
        line_y = 10'd2; line_start = 1'b1; cyc = 0;
        tick();
        line_start = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            check("addrA", 32'(sram_bus.SRAM_ADDR), 32'(320 + k - 1));
            if (k == 1) begin
                check("busyA_start", 32'(busy), 1);
                check("ceA_start", 32'(sram_bus.SRAM_CE_N), 0);
                check("oeA_start", 32'(sram_bus.SRAM_OE_N), 0);
            end
            tick();
        end
        check("busyA_161", 32'(busy), 1);
        check("ceA_161", 32'(sram_bus.SRAM_CE_N), 0);
        tick();
        check("busyA_162", 32'(busy), 0);
        check("ceA_162", 32'(sram_bus.SRAM_CE_N), 1);
        check("oeA_162", 32'(sram_bus.SRAM_OE_N), 1);

        // Fetch B: row 0 with address-dependent data; A's bank is now displayed
        use_model = 1'b1;
        line_y = 10'd0; line_start = 1'b1; cyc = 0;
        tick();
        line_start = 1'b0;
        check("underrun_swap", 32'(underrun), 0);
        for (int i = 0; i < 4; i++) begin
            rd_x = 10'(i);
            tick();
            check("pixA", 32'(pix_out), 32'(i));
        end
        rd_x = 10'd639; tick(); check("pixA_639", 32'(pix_out), 3);
        rd_x = 10'd640; tick(); check("pixA_640", 32'(pix_out), 0);
        rd_x = 10'd1023; tick(); check("pixA_1023", 32'(pix_out), 0);
        check("addrB", 32'(sram_bus.SRAM_ADDR), 32'(cyc - 1));
        while (cyc < 161) begin
            x = 4 * (cyc % 160) + (cyc % 4);
            rd_x = 10'(x);
            tick();
            check("pix_hold", 32'(pix_out), 32'(x % 4));
        end

        // Start coincident with B's final write: swap, no underrun
        check("busyB_161", 32'(busy), 1);
        line_y = 10'd5; line_start = 1'b1; cyc = 0;
        tick();
        line_start = 1'b0;
        check("underrun_coinc", 32'(underrun), 0);
        check("addrC_first", 32'(sram_bus.SRAM_ADDR), 32'(base_c));
        check("busyC", 32'(busy), 1);
        foreach (xs[i]) begin
            rd_x = 10'(xs[i]);
            tick();
            check("pixB", 32'(pix_out), 32'(exp_pix(xs[i])));
        end
        while (cyc < 50) tick();

        // Start during FETCH: underrun, restart into the same fill bank
        line_y = 10'd3; line_start = 1'b1; cyc = 0;
        tick();
        line_start = 1'b0;
        check("underrun_set", 32'(underrun), 1);
        check("addrD_first", 32'(sram_bus.SRAM_ADDR), 32'(base_d));
        rd_x = 10'd5;
        tick();
        check("pixB_kept", 32'(pix_out), 32'(exp_pix(5)));
        check("addrD_second", 32'(sram_bus.SRAM_ADDR), 32'(base_d + 20'd1));
        while (cyc < 80) tick();
        check("underrun_sticky", 32'(underrun), 1);

        // Reset mid-fetch aborts immediately
        Reset_n = 1'b0;
        tick();
        check("abort_ce", 32'(sram_bus.SRAM_CE_N), 1);
        check("abort_oe", 32'(sram_bus.SRAM_OE_N), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_addr", 32'(sram_bus.SRAM_ADDR), 0);
        check("abort_underrun", 32'(underrun), 0);
        check("abort_pix", 32'(pix_out), 0);
        Reset_n = 1'b1;
        tick(); tick();
        check("idle_addr", 32'(sram_bus.SRAM_ADDR), 0);
        check("idle_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameter FB_BASE, default 20'h00000: SRAM word address of framebuffer row 0.
REQ-002 Parameter H_PIXELS, default 640: visible pixels per line; multiple of 4; WORDS = H_PIXELS/4 (160 at default).
REQ-003 Clk  in  1: single clock, 50 MHz; all logic on its rising edge.
REQ-004 Reset_n  in  1: synchronous, active-low reset.
REQ-005 line_start  in  1: one-cycle pulse requesting fetch of row line_y; issued once per line, ahead of display.
REQ-006 line_y  in  10: framebuffer row for the fetch; sampled only on line_start.
REQ-007 SRAM_ADDR  out  20: SRAM word address.
REQ-008 SRAM_CE_N  out  1: active-low SRAM chip enable.
REQ-009 SRAM_OE_N  out  1: active-low SRAM output enable.
REQ-010 sram_rdata  in  16: SRAM read data, valid one cycle after SRAM_ADDR; pixel 4k+i occupies bits [4i+3:4i].
REQ-011 rd_x  in  10: display-side pixel column, 0..H_PIXELS-1.
REQ-012 pix_out  out  4: colour index of display-bank pixel rd_x, feeding color_mapper.
REQ-013 busy  out  1: high while a fetch is in progress.
REQ-014 underrun  out  1: sticky; set when a line_start arrives before the previous fetch completes.

Function
REQ-015 Two line banks, each WORDS x 16 bits; one is the display bank (read side) and the other the fill bank (write side).
REQ-016 FSM states IDLE, FETCH, DRAIN; IDLE->FETCH on line_start; FETCH->DRAIN after issuing address WORDS-1; DRAIN->IDLE after the final write.
REQ-017 On line_start in IDLE: swap banks, latch row = line_y, reset word counter w to 0, assert busy the next cycle.
REQ-018 In FETCH: SRAM_ADDR = FB_BASE + row*WORDS + w, w increments by 1 per cycle; CE_N and OE_N are 0 in FETCH and DRAIN, 1 otherwise.
REQ-019 The address computation uses a 20-bit result; overflow wraps modulo 2^20 without error.
REQ-020 Each cycle after an address is issued, sram_rdata is written to fill-bank word w-1 (one whole word, four pixels).
REQ-021 Timing: line_start at cycle 0; first address at cycle 1; first write at cycle 2; last address at cycle WORDS; last write at cycle WORDS+1; busy low from cycle WORDS+2 (162 at default).
REQ-022 Read side: pix_out = nibble rd_x[1:0] of display-bank word rd_x>>2, registered; latency 1 cycle; updates every cycle, independent of FSM state.
REQ-023 rd_x >= H_PIXELS returns pix_out 4'h0.
REQ-024 line_start while busy: set underrun, do not swap banks, abort the current fetch, and restart at w=0 into the same fill bank with the new line_y (restart timing per REQ-021).
REQ-025 Simultaneous line_start and final DRAIN write: the write completes and the line_start is treated as arriving in IDLE (swap, no underrun).
REQ-026 underrun clears only on reset.
REQ-027 Fill-bank writes never alter display-bank read data in the same or any later cycle before the next swap.

Reset
REQ-028 When Reset_n=0 at a rising edge: FSM to IDLE, SRAM_ADDR=0, SRAM_CE_N=1, SRAM_OE_N=1, busy=0, underrun=0, pix_out=0, display bank=0, fill bank=1, w=0.
REQ-029 Bank contents are not reset; pix_out is undefined-but-stable until the first completed fetch and swap.
REQ-030 Reset asserted mid-fetch aborts immediately, with no further SRAM_ADDR changes or writes.

Configuration
REQ-031 Macro PIXEL_FETCH_LINE_DOUBLE_EN defined: latched row = line_y[9:1] (each framebuffer row serves two display lines, 240-row buffer); undefined: row = line_y.

Verification
REQ-032 Reset, FB_BASE=0, sram_rdata=16'h3210 constant, line_start with line_y=2 -> SRAM_ADDR 320..479 on cycles 1..160, busy low at cycle 162.
REQ-033 After REQ-032 fetch, second line_start (swap) then rd_x=0,1,2,3 -> pix_out 0,1,2,3 one cycle after each.
REQ-034 line_start at cycle 50 of a fetch -> underrun=1, SRAM_ADDR restarts at the new row base on the next cycle, display bank unchanged.
REQ-035 line_start coincident with the final write (cycle 161) -> banks swap, underrun stays 0, new fetch starts.
REQ-036 With PIXEL_FETCH_LINE_DOUBLE_EN, line_y=5 -> first SRAM_ADDR=320; without the macro -> 800.
REQ-037 Reset_n low at cycle 80 of a fetch -> next cycle CE_N=OE_N=1, busy=0, SRAM_ADDR=0.
